// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    REPEAT  = 2'd2,
    HELD_NR = 2'd3
  } rep_state_t;

  localparam int DEF_N_BTN        = 3;
  localparam int DEF_SAMPLE_DIV   = 500000;
  localparam int DEF_STABLE_CNT   = 4;
  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE  = 10;
  localparam logic [2:0] DEF_REPEAT_MASK = 3'b011;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_chan.sv
// One button: 2-FF synchroniser, tick-sampled debounce and typematic repeat FSM.
//   state   | meaning
//   IDLE    | released (or waiting for first debounced press)
//   DELAY   | held, counting ticks to the first repeat
//   REPEAT  | held, emitting a pulse every REPEAT_RATE ticks
//   HELD_NR | held, repeat disabled for this button
module btn_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tick,
  input  logic btn_n,
  output logic pulse,
  output logic level
);

  localparam int SW = $clog2(STABLE_CNT + 1);
  localparam int HW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [SW-1:0] STABLE_TC = SW'(STABLE_CNT - 1);
  localparam logic [HW-1:0] DELAY_TC  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] RATE_TC   = HW'(REPEAT_RATE - 1);

  logic [1:0]    sync;
  logic          sample_pressed;
  logic          db_pressed;
  logic [SW-1:0] db_cnt;
  logic          disagree;
  logic          flip;
  logic          press_flip;
  logic          release_flip;

  rep_state_t    state, state_n;
  logic [HW-1:0] hc, hc_n;
  logic          pulse_n;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync <= 2'b11;
    else        sync <= {sync[0], btn_n};
  end

  assign sample_pressed = ~sync[1];
  assign disagree       = sample_pressed ^ db_pressed;
  assign flip           = tick & disagree & (db_cnt == STABLE_TC);
  assign press_flip     = flip & ~db_pressed;
  assign release_flip   = flip & db_pressed;

  // The counter clears on the flipping tick instead of reaching STABLE_CNT.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      db_cnt     <= '0;
      db_pressed <= 1'b0;
    end else if (tick) begin
      if (!disagree) begin
        db_cnt <= '0;
      end else if (db_cnt == STABLE_TC) begin
        db_cnt     <= '0;
        db_pressed <= ~db_pressed;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = db_pressed;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      hc    <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      hc    <= hc_n;
      pulse <= pulse_n;
    end
  end

  // Release is tested first so it wins over a repeat due on the same tick.
  always_comb begin
    state_n = state;
    hc_n    = hc;
    pulse_n = 1'b0;
    if (tick) begin
      if (release_flip) begin
        state_n = IDLE;
        hc_n    = '0;
      end else begin
        case (state)
          IDLE: begin
            if (press_flip) begin
              pulse_n = 1'b1;
              hc_n    = '0;
              state_n = REPEAT_EN ? DELAY : HELD_NR;
            end
          end
          DELAY: begin
            if (hc == DELAY_TC) begin
              pulse_n = 1'b1;
              hc_n    = '0;
              state_n = REPEAT;
            end else begin
              hc_n = hc + 1'b1;
            end
          end
          REPEAT: begin
            if (hc == RATE_TC) begin
              pulse_n = 1'b1;
              hc_n    = '0;
            end else begin
              hc_n = hc + 1'b1;
            end
          end
          HELD_NR: state_n = HELD_NR;
          default: begin
            state_n = IDLE;
            hc_n    = '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_repeat.sv
// Button conditioner top: shared sample-tick prescaler feeding one channel per button.
module btn_repeat
  import btn_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int SAMPLE_DIV   = DEF_SAMPLE_DIV,
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter logic [N_BTN-1:0] REPEAT_MASK = N_BTN'(DEF_REPEAT_MASK)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_BTN-1:0] btn_level
);

  localparam int PW = $clog2(SAMPLE_DIV + 1);
  localparam logic [PW-1:0] DIV_TC = PW'(SAMPLE_DIV - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == DIV_TC);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)    pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    btn_chan #(
      .STABLE_CNT   (STABLE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (REPEAT_MASK[i])
    ) u_chan (
      .clk   (clk),
      .n_rst (n_rst),
      .tick  (tick),
      .btn_n (btn[i]),
      .pulse (btn_out[i]),
      .level (btn_level[i])
    );
  end

endmodule

// File: tb/tb_btn_repeat.sv
// Directed bench for btn_repeat with SAMPLE_DIV=4, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_RATE=2.
module tb_btn_repeat;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] btn = 3'b111;
  logic [2:0] btn_out;
  logic [2:0] btn_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  btn_repeat #(
    .N_BTN        (3),
    .SAMPLE_DIV   (4),
    .STABLE_CNT   (3),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2),
    .REPEAT_MASK  (3'b011)
  ) u_dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .btn       (btn),
    .btn_out   (btn_out),
    .btn_level (btn_level)
  );

  typedef struct {
    logic [2:0] btn;
    int         len;
    int         exp_p0;
    int         exp_p1;
    int         exp_p2;
    logic [2:0] exp_level;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int p0, p1, p2;
    logic [2:0] prev;
    logic dbl;

    // Segments start on cycles with index = 0 mod 4, so each press flips 11 cycles in.
    vecs[0]  = '{3'b111, 100, 0, 0, 0, 3'b000};
    vecs[1]  = '{3'b110,  60, 5, 0, 0, 3'b001};
    vecs[2]  = '{3'b111,  20, 1, 0, 0, 3'b000};
    for (int i = 0; i < 5; i++) begin
      vecs[3 + 2*i] = '{3'b110, 4, 0, 0, 0, 3'b000};
      vecs[4 + 2*i] = '{3'b111, 4, 0, 0, 0, 3'b000};
    end
    vecs[13] = '{3'b111,  20, 0, 0, 0, 3'b000};
    vecs[14] = '{3'b011, 200, 0, 0, 1, 3'b100};
    vecs[15] = '{3'b111,  20, 0, 0, 0, 3'b000};
    vecs[16] = '{3'b100,  32, 2, 2, 0, 3'b011};
    vecs[17] = '{3'b111,  20, 1, 1, 0, 3'b000};
    vecs[18] = '{3'b101,  36, 0, 2, 0, 3'b010};
    vecs[19] = '{3'b111,  20, 0, 1, 0, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    check("reset btn_out", 32'(btn_out), 32'd0);
    check("reset btn_level", 32'(btn_level), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    cyc = -1;
    step();

    for (int v = 0; v < 20; v++) begin
      btn  = vecs[v].btn;
      p0   = 0;
      p1   = 0;
      p2   = 0;
      prev = btn_out;
      dbl  = 1'b0;
      for (int k = 0; k < vecs[v].len; k++) begin
        step();
        if (btn_out[0]) p0++;
        if (btn_out[1]) p1++;
        if (btn_out[2]) p2++;
        if ((prev & btn_out) != 3'b000) dbl = 1'b1;
        prev = btn_out;
        check($sformatf("tick c%0d", cyc), 32'(u_dut.tick), 32'((cyc % 4) == 2));
      end
      check($sformatf("vec%0d pulses0", v), p0, vecs[v].exp_p0);
      check($sformatf("vec%0d pulses1", v), p1, vecs[v].exp_p1);
      check($sformatf("vec%0d pulses2", v), p2, vecs[v].exp_p2);
      check($sformatf("vec%0d level", v), 32'(btn_level), 32'(vecs[v].exp_level));
      check($sformatf("vec%0d double pulse", v), 32'(dbl), 32'd0);
    end

    check("btn1 state after coincident release",
          32'(u_dut.g_chan[1].u_chan.state), 32'(btn_pkg::IDLE));

    // Hold btn0 into REPEAT and reset on a repeat-pulse cycle (flip 579, repeats 599, 607).
    btn = 3'b110;
    repeat (39) step();
    check("pre-reset pulse", 32'(btn_out[0]), 32'd1);
    check("pre-reset level", 32'(btn_level[0]), 32'd1);
    check("pre-reset state", 32'(u_dut.g_chan[0].u_chan.state), 32'(btn_pkg::REPEAT));
    n_rst = 1'b0;
    #1;
    check("mid-hold reset btn_out", 32'(btn_out), 32'd0);
    check("mid-hold reset btn_level", 32'(btn_level), 32'd0);
    check("mid-hold reset state", 32'(u_dut.g_chan[0].u_chan.state), 32'(btn_pkg::IDLE));
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    cyc = -1;
    for (int k = 0; k < 41; k++) begin
      step();
      check($sformatf("post-reset out c%0d", cyc), 32'(btn_out[0]),
            32'(cyc == 11 || cyc == 31 || cyc == 39));
      check($sformatf("post-reset level c%0d", cyc), 32'(btn_level[0]), 32'(cyc >= 11));
      check($sformatf("post-reset tick c%0d", cyc), 32'(u_dut.tick), 32'((cyc % 4) == 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
